// File: rtl/prbs_ber_checker.sv
// PRBS bit-error-rate checker.
// Learns the incoming PRBS sequence by loading received bits into an LFSR (SEED).
// It then confirms alignment against LOCK_COUNT consecutive matching bits (VERIFY).
// Once LOCKED, it free-runs on its own predictions and counts checked bits and bit errors.
// Ports:
//   clk, rstn            - clock, synchronous active-low reset
//   en                   - global enable; low holds all state
//   clear                - synchronous soft clear, relatches prbs_sel
//   prbs_sel[1:0]        - 00 PRBS7, 01 PRBS15, 1x PRBS31
//   data_in, data_in_valid - received bit and its qualifier
//   locked               - aligned to the sequence
//   total_bits, total_bit_errors - saturating counts, updated only while locked
//   relock_count[7:0]    - lock losses since reset/clear, saturating
// Optional feature: define PRBS_LOCK_LOSS_EN to drop lock when ERR_LOSS_THRESH errors
// occur within one ERR_LOSS_WINDOW-bit window.
module prbs_ber_checker #(
  parameter int unsigned COUNT_WIDTH     = 32,
  parameter int unsigned LOCK_COUNT      = 32,
  parameter int unsigned ERR_LOSS_THRESH = 8,
  parameter int unsigned ERR_LOSS_WINDOW = 64
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   clear,
  input  logic [1:0]             prbs_sel,
  input  logic                   data_in,
  input  logic                   data_in_valid,
  output logic                   locked,
  output logic [COUNT_WIDTH-1:0] total_bits,
  output logic [COUNT_WIDTH-1:0] total_bit_errors,
  output logic [7:0]             relock_count
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {StSeed, StVerify, StLocked} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             poly_q, poly_d;
  logic [30:0]            lfsr_q, lfsr_d;
  logic [4:0]             load_q, load_d;
  logic [MW-1:0]          match_q, match_d;
  logic [COUNT_WIDTH-1:0] bits_q, bits_d;
  logic [COUNT_WIDTH-1:0] errs_q, errs_d;

`ifdef PRBS_LOCK_LOSS_EN
  localparam int unsigned WW = $clog2(ERR_LOSS_WINDOW + 1);
  localparam int unsigned EW = $clog2(ERR_LOSS_THRESH + 1);
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [EW-1:0] win_err_q, win_err_d;
  logic [7:0]    relock_q, relock_d;
`endif

  logic       accept;
  logic       pred;
  logic       mismatch;
  logic [4:0] seed_last;

  assign accept = en & data_in_valid & ~clear;

  // Feedback taps and seed length follow the latched polynomial, never prbs_sel directly.
  always_comb begin
    pred      = lfsr_q[30] ^ lfsr_q[27];
    seed_last = 5'd30;
    case (poly_q)
      2'b00: begin
        pred      = lfsr_q[6] ^ lfsr_q[5];
        seed_last = 5'd6;
      end
      2'b01: begin
        pred      = lfsr_q[14] ^ lfsr_q[13];
        seed_last = 5'd14;
      end
      default: ;
    endcase
  end

  assign mismatch = data_in ^ pred;

  always_comb begin
    state_d = state_q;
    poly_d  = poly_q;
    lfsr_d  = lfsr_q;
    load_d  = load_q;
    match_d = match_q;
    bits_d  = bits_q;
    errs_d  = errs_q;
`ifdef PRBS_LOCK_LOSS_EN
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    relock_d  = relock_q;
`endif
    if (clear) begin
      state_d = StSeed;
      poly_d  = prbs_sel;
      lfsr_d  = '0;
      load_d  = '0;
      match_d = '0;
      bits_d  = '0;
      errs_d  = '0;
`ifdef PRBS_LOCK_LOSS_EN
      win_cnt_d = '0;
      win_err_d = '0;
      relock_d  = '0;
`endif
    end else if (accept) begin
      unique case (state_q)
        StSeed: begin
          lfsr_d = {lfsr_q[29:0], data_in};
          if (load_q == seed_last) begin
            state_d = StVerify;
            load_d  = '0;
            match_d = '0;
          end else begin
            load_d = load_q + 5'd1;
          end
        end
        StVerify: begin
          lfsr_d = {lfsr_q[29:0], data_in};
          if (mismatch) begin
            state_d = StSeed;
            load_d  = '0;
            match_d = '0;
          end else if (match_q == MW'(LOCK_COUNT - 1)) begin
            state_d = StLocked;
            match_d = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        StLocked: begin
          // Free-run on the prediction so a corrupted bit cannot misalign the LFSR.
          lfsr_d = {lfsr_q[29:0], pred};
          if (bits_q != '1) bits_d = bits_q + 1'b1;
          if (mismatch && errs_q != '1) errs_d = errs_q + 1'b1;
`ifdef PRBS_LOCK_LOSS_EN
          if (mismatch && win_err_q == EW'(ERR_LOSS_THRESH - 1)) begin
            state_d   = StSeed;
            load_d    = '0;
            win_cnt_d = '0;
            win_err_d = '0;
            if (relock_q != 8'hff) relock_d = relock_q + 8'd1;
          end else if (win_cnt_q == WW'(ERR_LOSS_WINDOW - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_q + EW'(mismatch);
          end
`endif
        end
        default: state_d = StSeed;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StSeed;
      poly_q  <= prbs_sel;  // value present when reset releases is the one kept
      lfsr_q  <= '0;
      load_q  <= '0;
      match_q <= '0;
      bits_q  <= '0;
      errs_q  <= '0;
`ifdef PRBS_LOCK_LOSS_EN
      win_cnt_q <= '0;
      win_err_q <= '0;
      relock_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      poly_q  <= poly_d;
      lfsr_q  <= lfsr_d;
      load_q  <= load_d;
      match_q <= match_d;
      bits_q  <= bits_d;
      errs_q  <= errs_d;
`ifdef PRBS_LOCK_LOSS_EN
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      relock_q  <= relock_d;
`endif
    end
  end

  assign locked           = (state_q == StLocked);
  assign total_bits       = bits_q;
  assign total_bit_errors = errs_q;
`ifdef PRBS_LOCK_LOSS_EN
  assign relock_count = relock_q;
`else
  assign relock_count = 8'd0;
`endif

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Directed bench for prbs_ber_checker: a 32-bit-counter instance and an 8-bit-counter
// instance share all inputs. The bench generates PRBS data from its own LFSR model.
module tb_prbs_ber_checker;

  logic        clk = 1'b0;
  logic        rstn, en, clear, data_in, data_in_valid;
  logic [1:0]  prbs_sel;
  logic        locked, locked8;
  logic [31:0] total_bits, total_bit_errors;
  logic [7:0]  total_bits8, total_bit_errors8;
  logic [7:0]  relock_count, relock_count8;

  int checks = 0;
  int errors = 0;

  logic [30:0] g;
  logic [1:0]  gpoly;

  always #5 clk = ~clk;

  prbs_ber_checker dut (
    .clk             (clk),
    .rstn            (rstn),
    .en              (en),
    .clear           (clear),
    .prbs_sel        (prbs_sel),
    .data_in         (data_in),
    .data_in_valid   (data_in_valid),
    .locked          (locked),
    .total_bits      (total_bits),
    .total_bit_errors(total_bit_errors),
    .relock_count    (relock_count)
  );

  prbs_ber_checker #(.COUNT_WIDTH(8)) dut8 (
    .clk             (clk),
    .rstn            (rstn),
    .en              (en),
    .clear           (clear),
    .prbs_sel        (prbs_sel),
    .data_in         (data_in),
    .data_in_valid   (data_in_valid),
    .locked          (locked8),
    .total_bits      (total_bits8),
    .total_bit_errors(total_bit_errors8),
    .relock_count    (relock_count8)
  );

  function automatic logic tap(input logic [30:0] s, input logic [1:0] p);
    case (p)
      2'b00:   return s[6] ^ s[5];
      2'b01:   return s[14] ^ s[13];
      default: return s[30] ^ s[27];
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One valid bit from the reference generator, optionally inverted; outputs sampled #1 later.
  task automatic send(input logic flip);
    logic b;
    b = tap(g, gpoly);
    g = {g[29:0], b};
    data_in = b ^ flip;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input logic flip);
    for (int i = 0; i < n; i++) send(flip);
  endtask

  task automatic restart_gen(input logic [1:0] p);
    gpoly = p;
    g = 31'h1;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; clear = 1'b0; data_in = 1'b0; data_in_valid = 1'b0;
    prbs_sel = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_bits", total_bits, 32'd0);
    check("rst_errs", total_bit_errors, 32'd0);
    check("rst_relock", {24'd0, relock_count}, 32'd0);
    rstn = 1'b1;

    // PRBS31 acquisition: 31 seed + 32 verify bits.
    restart_gen(2'b10);
    send_n(62, 1'b0);
    check("p31_not_yet", {31'd0, locked}, 32'd0);
    send(1'b0);
    check("p31_locked", {31'd0, locked}, 32'd1);
    check("p31_bits0", total_bits, 32'd0);
    send_n(100, 1'b0);
    check("p31_bits100", total_bits, 32'd100);
    check("p31_errs0", total_bit_errors, 32'd0);
    check("w8_bits100", {24'd0, total_bits8}, 32'd100);
    send_n(200, 1'b0);
    check("p31_bits300", total_bits, 32'd300);
    check("w8_bits_sat", {24'd0, total_bits8}, 32'd255);
    check("w8_errs0", {24'd0, total_bit_errors8}, 32'd0);

    // en low: toggling valid data must be ignored.
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data_in = i[0];
      data_in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    data_in_valid = 1'b0;
    en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("en_hold_bits", total_bits, 32'd300);
    check("en_hold_lock", {31'd0, locked}, 32'd1);

    // Burst of 8 errors inside one window.
    send_n(7, 1'b1);
    check("burst7_lock", {31'd0, locked}, 32'd1);
    check("burst7_errs", total_bit_errors, 32'd7);
    send(1'b1);
    check("burst8_errs", total_bit_errors, 32'd8);
    check("burst8_bits", total_bits, 32'd308);
`ifdef PRBS_LOCK_LOSS_EN
    check("loss_lock", {31'd0, locked}, 32'd0);
    check("loss_relock", {24'd0, relock_count}, 32'd1);
    send_n(62, 1'b0);
    check("relock_not_yet", {31'd0, locked}, 32'd0);
    send(1'b0);
    check("relock_locked", {31'd0, locked}, 32'd1);
    check("relock_bits_kept", total_bits, 32'd308);
    check("relock_errs_kept", total_bit_errors, 32'd8);
    send_n(10, 1'b0);
    check("relock_bits_more", total_bits, 32'd318);
    check("relock_cnt", {24'd0, relock_count}, 32'd1);
`else
    check("noloss_lock", {31'd0, locked}, 32'd1);
    check("noloss_relock", {24'd0, relock_count}, 32'd0);
    send_n(63, 1'b0);
    check("noloss_bits", total_bits, 32'd371);
    check("noloss_errs", total_bit_errors, 32'd8);
    // Every bit errored: 8-bit counters pin at 255.
    send_n(300, 1'b1);
    check("w8_bits_sat2", {24'd0, total_bits8}, 32'd255);
    check("w8_errs_sat", {24'd0, total_bit_errors8}, 32'd255);
    check("allerr_errs", total_bit_errors, 32'd308);
    send_n(20, 1'b0);
    check("allerr_clean", total_bit_errors, 32'd308);
    check("allerr_bits", total_bits, 32'd691);
`endif

    // Clear with a coincident valid bit (discarded) and polynomial change to PRBS15.
    prbs_sel = 2'b01;
    clear = 1'b1;
    data_in = 1'b1;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    data_in_valid = 1'b0;
    check("clr_bits", total_bits, 32'd0);
    check("clr_errs", total_bit_errors, 32'd0);
    check("clr_lock", {31'd0, locked}, 32'd0);
    check("clr_relock", {24'd0, relock_count}, 32'd0);
    restart_gen(2'b01);
    send_n(46, 1'b0);
    check("p15_not_yet", {31'd0, locked}, 32'd0);
    send(1'b0);
    check("p15_locked", {31'd0, locked}, 32'd1);
    prbs_sel = 2'b00;
    send_n(20, 1'b0);
    check("p15_sel_ignored_bits", total_bits, 32'd20);
    check("p15_sel_ignored_errs", total_bit_errors, 32'd0);

    // Same via reset pulse.
    prbs_sel = 2'b01;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_bits", total_bits, 32'd0);
    check("rst2_lock", {31'd0, locked}, 32'd0);
    rstn = 1'b1;
    restart_gen(2'b01);
    send_n(46, 1'b0);
    check("rst2_not_yet", {31'd0, locked}, 32'd0);
    send(1'b0);
    check("rst2_locked", {31'd0, locked}, 32'd1);
    prbs_sel = 2'b00;
    send_n(20, 1'b0);
    check("rst2_bits20", total_bits, 32'd20);
    check("rst2_errs0", total_bit_errors, 32'd0);

    // PRBS7 with a single flipped bit.
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    restart_gen(2'b00);
    send_n(38, 1'b0);
    check("p7_not_yet", {31'd0, locked}, 32'd0);
    send(1'b0);
    check("p7_locked", {31'd0, locked}, 32'd1);
    send_n(10, 1'b0);
    send(1'b1);
    check("p7_flip_errs", total_bit_errors, 32'd1);
    check("p7_flip_lock", {31'd0, locked}, 32'd1);
    check("p7_flip_bits", total_bits, 32'd11);
    send_n(20, 1'b0);
    check("p7_after_errs", total_bit_errors, 32'd1);
    check("p7_after_bits", total_bits, 32'd31);
    check("p7_after_lock", {31'd0, locked}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs_ber_checker.md
PRBS_BER_CHECKER -- requirements
Module: prbs_ber_checker

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 32, width of the bit and error counters.
REQ-002 SHALL have parameter LOCK_COUNT, default 32, consecutive matching bits needed to declare lock.
REQ-003 SHALL have parameter ERR_LOSS_THRESH, default 8, errors within one window that cause loss of lock.
REQ-004 SHALL have parameter ERR_LOSS_WINDOW, default 64, valid-bit length of the loss-of-lock window.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rstn  input  1  synchronous active-low reset.
REQ-007 SHALL have port en  input  1  enable; when low, inputs are ignored and all state holds.
REQ-008 SHALL have port clear  input  1  synchronous soft clear of counters and lock state.
REQ-009 SHALL have port prbs_sel  input  2  polynomial select: 00 PRBS7 (x^7+x^6+1), 01 PRBS15 (x^15+x^14+1), 10/11 PRBS31 (x^31+x^28+1).
REQ-010 SHALL have port data_in  input  1  received bit.
REQ-011 SHALL have port data_in_valid  input  1  data_in qualifier.
REQ-012 SHALL have port locked  output  1  checker is aligned to the sequence.
REQ-013 SHALL have port total_bits  output  COUNT_WIDTH  valid bits checked while locked.
REQ-014 SHALL have port total_bit_errors  output  COUNT_WIDTH  mismatched bits while locked.
REQ-015 SHALL have port relock_count  output  8  number of lock losses since reset/clear, saturating at 255.

Function
REQ-016 SHALL implement FSM states SEED, VERIFY, LOCKED; a bit is "accepted" only when en=1, data_in_valid=1, clear=0.
REQ-017 SEED: each accepted bit shifts into the LFSR; after N accepted bits (N = 7/15/31 per latched polynomial) SHALL go to VERIFY.
REQ-018 VERIFY: each accepted bit compared to the LFSR prediction and shifted in as received; a mismatch SHALL return to SEED with the load count cleared; LOCK_COUNT consecutive matches SHALL go to LOCKED.
REQ-019 LOCKED: the LFSR SHALL advance on its own predicted bit (not the received bit); every accepted bit increments total_bits, every mismatch increments total_bit_errors.
REQ-020 Counter and locked updates SHALL be registered: effect of a bit accepted in cycle N visible in cycle N+1.
REQ-021 total_bits and total_bit_errors SHALL saturate independently at all-ones and never wrap.
REQ-022 Polynomial SHALL be latched from prbs_sel at reset release and on clear; prbs_sel changes at other times SHALL have no effect.
REQ-023 clear SHALL zero counters and relock_count, deassert locked, enter SEED with load count 0 and relatch prbs_sel; clear coincident with a valid bit discards that bit.
REQ-024 With no accepted bits, all state SHALL hold, including across en low periods of any length.

Reset
REQ-025 rstn=0 at a rising edge SHALL force: state SEED, load/match counts 0, LFSR 0, locked 0, total_bits 0, total_bit_errors 0, relock_count 0, window counters 0.
REQ-026 Reset SHALL take priority over clear, en and data; reset mid-lock SHALL discard lock and counts with no partial update.

Configuration
REQ-027 Macro PRBS_LOCK_LOSS_EN SHALL gate loss-of-lock detection.
REQ-028 With PRBS_LOCK_LOSS_EN defined: in LOCKED, a window counter counts accepted bits and a window error counter counts mismatches; when errors reach ERR_LOSS_THRESH within ERR_LOSS_WINDOW bits, SHALL go to SEED, deassert locked next cycle, increment relock_count, keep total counters; both window counters reset at window end and on leaving LOCKED.
REQ-029 Without PRBS_LOCK_LOSS_EN: LOCKED SHALL be left only by reset or clear; relock_count SHALL be constant 0; no window logic synthesised.

Verification
REQ-030 Reset, clear-free error-free PRBS31 stream, valid every cycle -> locked=1 the cycle after the 63rd bit (31+32); after 100 further bits total_bits=100, total_bit_errors=0.
REQ-031 PRBS7 selected, locked, one bit flipped -> total_bit_errors=1, locked stays 1, LFSR not disturbed (subsequent errors 0).
REQ-032 PRBS_LOCK_LOSS_EN defined, locked, 8 bits flipped within 64 -> locked=0 the cycle after the 8th error, relock_count=1, clean data resumes -> relock after 31+32 bits, counters retained.
REQ-033 PRBS_LOCK_LOSS_EN undefined, same 8-error burst -> locked stays 1, total_bit_errors=8, relock_count=0.
REQ-034 COUNT_WIDTH=8, locked, 300 bits with every bit errored -> total_bits=255, total_bit_errors=255, no wrap.
REQ-035 Mid-run clear with prbs_sel changed 10->01, then PRBS15 data -> counters 0, locked after 15+32 bits; repeat with rstn pulse -> identical result.
